// File: rtl/mvm_pkg.sv
// Shared defaults, accumulator width and controller state encoding for the
// 8x8 matrix-vector multiplier.
package mvm_pkg;

  localparam int DATA_WIDTH = 8;
  localparam int DEPTH      = 8;
  localparam int NUM_ROWS   = 8;
  localparam int ACC_WIDTH  = 3 * DATA_WIDTH;

  typedef enum logic [1:0] {
    FILL    = 2'd0,
    COMPUTE = 2'd1,
    DONE    = 2'd2
  } mvm_state_e;

endpackage

// File: rtl/mvm_fifo.sv
// Synchronous show-ahead FIFO: the head entry is visible combinationally.
// A low clr_n empties it on the next edge and blocks that cycle's write/read.
module mvm_fifo
  import mvm_pkg::*;
#(
  parameter int DW    = DATA_WIDTH,
  parameter int DEPTH = mvm_pkg::DEPTH
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_n,
  input  logic          wren,
  input  logic          rden,
  input  logic [DW-1:0] din,
  output logic          full,
  output logic          empty,
  output logic [DW-1:0] head
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_wr, w_rd;

  assign full  = (r_count == (AW+1)'(DEPTH));
  assign empty = (r_count == '0);
  assign head  = r_mem[r_rd_ptr];

  // Full-drop and empty-pop are silently ignored.
  assign w_wr = clr_n & wren & ~full;
  assign w_rd = clr_n & rden & ~empty;

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (!clr_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + 1'b1;
      if (w_rd) r_rd_ptr <= (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + 1'b1;
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/mat_vec_mult.sv
// 8x8 matrix times 8-vector: eight row FIFOs and one vector FIFO feed eight
// MAC lanes in lockstep. Define MVM_SIGNED_EN for two's-complement operands.
module mat_vec_mult #(
  parameter int DATA_WIDTH = mvm_pkg::DATA_WIDTH,
  parameter int DEPTH      = mvm_pkg::DEPTH,
  parameter int NUM_ROWS   = mvm_pkg::NUM_ROWS
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      Clr,
  input  logic                      a_wren,
  input  logic                      b_wren,
  input  logic [DATA_WIDTH-1:0]     a_fifo_in [7:0],
  input  logic [DATA_WIDTH-1:0]     b_fifo_in,
  output logic [3*DATA_WIDTH-1:0]   out       [7:0]
);
  import mvm_pkg::*;

  localparam int ACC_W = 3 * DATA_WIDTH;
  localparam int PRD_W = 2 * DATA_WIDTH;
  localparam logic [2:0] LAST_COL = 3'(DEPTH - 1);

  mvm_state_e              r_state;
  logic [2:0]              r_col;
  logic [ACC_W-1:0]        r_acc    [8];
  logic [DATA_WIDTH-1:0]   w_a_head [8];
  logic [7:0]              w_a_full;
  logic [DATA_WIDTH-1:0]   w_b_head;
  logic                    w_b_full;
  logic                    w_fill, w_all_full, w_go, w_mac;

  assign w_fill     = (r_state == FILL);
  assign w_all_full = (&w_a_full) & w_b_full;
  // The edge that leaves FILL already consumes column 0, so the last write at
  // edge N leaves final results after edge N+DEPTH.
  assign w_go       = w_fill & w_all_full;
  assign w_mac      = w_go | (r_state == COMPUTE);

  for (genvar g = 0; g < 8; g++) begin : g_afifo
    logic w_empty_unused;
    mvm_fifo #(.DW(DATA_WIDTH), .DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .clr_n (Clr),
      .wren  (a_wren & w_fill),
      .rden  (w_mac),
      .din   (a_fifo_in[g]),
      .full  (w_a_full[g]),
      .empty (w_empty_unused),
      .head  (w_a_head[g])
    );
  end

  logic w_b_empty_unused;
  mvm_fifo #(.DW(DATA_WIDTH), .DEPTH(DEPTH)) u_bfifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_n (Clr),
    .wren  (b_wren & w_fill),
    .rden  (w_mac),
    .din   (b_fifo_in),
    .full  (w_b_full),
    .empty (w_b_empty_unused),
    .head  (w_b_head)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= FILL;
      r_col   <= '0;
    end else if (!Clr) begin
      r_state <= FILL;
      r_col   <= '0;
    end else begin
      case (r_state)
        FILL: if (w_all_full) begin
          r_state <= COMPUTE;
          r_col   <= 3'd1;
        end
        COMPUTE: begin
          r_col <= r_col + 1'b1;
          if (r_col == LAST_COL) begin
            r_state <= DONE;
            r_col   <= '0;
          end
        end
        DONE:    r_state <= DONE;
        default: r_state <= FILL;
      endcase
    end
  end

  for (genvar g = 0; g < 8; g++) begin : g_lane
    logic [ACC_W-1:0] w_prod_ext;
`ifdef MVM_SIGNED_EN
    logic signed [PRD_W-1:0] w_prod;
    assign w_prod     = $signed(w_a_head[g]) * $signed(w_b_head);
    assign w_prod_ext = {{(ACC_W-PRD_W){w_prod[PRD_W-1]}}, w_prod};
`else
    logic [PRD_W-1:0] w_prod;
    assign w_prod     = w_a_head[g] * w_b_head;
    assign w_prod_ext = {{(ACC_W-PRD_W){1'b0}}, w_prod};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)     r_acc[g] <= '0;
      else if (!Clr)  r_acc[g] <= '0;
      else if (w_mac) r_acc[g] <= r_acc[g] + w_prod_ext;
    end

    assign out[g] = r_acc[g];
  end

endmodule

// File: tb/tb_mat_vec_mult.sv
// Directed bench for mat_vec_mult: hand-computed results for each stimulus,
// including exact MAC latency, write drops, Clr abort and async reset.
module tb_mat_vec_mult;

  logic       clk = 1'b0;
  logic       rst_n, Clr, a_wren, b_wren;
  logic [7:0] a_fifo_in [7:0];
  logic [7:0] b_fifo_in;
  logic [23:0] out [7:0];

  logic [7:0] ma [8][8];
  logic [7:0] vb [8];
  int tests = 0;
  int fails = 0;

  mat_vec_mult dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .Clr       (Clr),
    .a_wren    (a_wren),
    .b_wren    (b_wren),
    .a_fifo_in (a_fifo_in),
    .b_fifo_in (b_fifo_in),
    .out       (out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_row(input string tag, input int i, input logic [23:0] exp);
    tests++;
    assert (out[i] === exp) else begin
      fails++;
      $error("FAIL %s row%0d: got %0d (0x%h), expected %0d (0x%h)", tag, i, out[i], out[i], exp, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [23:0] exp);
    for (int i = 0; i < 8; i++) check_row(tag, i, exp);
  endtask

  task automatic set_mat(input logic [7:0] av, input logic [7:0] bv);
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 8; j++) ma[i][j] = av;
      vb[i] = bv;
    end
  endtask

  // Last write lands on the final tick; caller is just after edge N.
  task automatic load(input bit together);
    if (together) begin
      for (int j = 0; j < 8; j++) begin
        for (int i = 0; i < 8; i++) a_fifo_in[i] = ma[i][j];
        b_fifo_in = vb[j];
        a_wren = 1'b1; b_wren = 1'b1;
        tick();
      end
    end else begin
      for (int j = 0; j < 8; j++) begin
        for (int i = 0; i < 8; i++) a_fifo_in[i] = ma[i][j];
        a_wren = 1'b1;
        tick();
      end
      a_wren = 1'b0;
      for (int j = 0; j < 8; j++) begin
        b_fifo_in = vb[j];
        b_wren = 1'b1;
        tick();
      end
    end
    a_wren = 1'b0; b_wren = 1'b0;
  endtask

  task automatic do_clr();
    Clr = 1'b0;
    tick();
    Clr = 1'b1;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  initial begin
    rst_n = 1'b0; Clr = 1'b1; a_wren = 1'b0; b_wren = 1'b0; b_fifo_in = '0;
    for (int i = 0; i < 8; i++) a_fifo_in[i] = '0;
    #3;
    check_all("reset_async", 24'd0);
    ticks(2);
    rst_n = 1'b1;
    tick();
    check_all("reset_state", 24'd0);

    // All ones, A then B; checks partial sum at N+4, then N+7 vs N+8 boundary.
    set_mat(8'd1, 8'd1);
    load(1'b0);
    check_all("ones_not_started", 24'd0);
    ticks(4);
    check_all("ones_partial4", 24'd4);
    ticks(3);
    check_all("ones_partial7", 24'd7);
    tick();
    check_all("ones_final", 24'd8);
    // Writes in DONE are ignored and out[] holds.
    for (int i = 0; i < 8; i++) a_fifo_in[i] = 8'd9;
    b_fifo_in = 8'd9; a_wren = 1'b1; b_wren = 1'b1;
    ticks(10);
    a_wren = 1'b0; b_wren = 1'b0;
    ticks(3);
    check_all("ones_held_done", 24'd8);

    do_clr();
    check_all("clr_after_done", 24'd0);

    // Overflow: 64 A write cycles, only the first 8 land.
    for (int j = 0; j < 64; j++) begin
      for (int i = 0; i < 8; i++) a_fifo_in[i] = (j < 8) ? 8'd1 : 8'd9;
      a_wren = 1'b1;
      tick();
    end
    a_wren = 1'b0;
    for (int j = 0; j < 8; j++) begin
      b_fifo_in = 8'd1; b_wren = 1'b1;
      tick();
    end
    b_wren = 1'b0;
    ticks(8);
    check_all("overflow_drop", 24'd8);
    do_clr();

    // Distinct rows, A and B written in the same cycles.
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 8; j++) ma[i][j] = 8'(i + 1);
      vb[i] = 8'(i + 1);
    end
    load(1'b1);
    ticks(8);
    check_row("distinct_row0", 0, 24'd36);
    check_row("distinct_row3", 3, 24'd144);
    check_row("distinct_row7", 7, 24'd288);
    for (int i = 0; i < 8; i++) check_row("distinct_rows", i, 24'((i + 1) * 36));
    do_clr();

    // Max operands; async reset from DONE afterwards.
    set_mat(8'd255, 8'd255);
    load(1'b0);
    ticks(8);
`ifdef MVM_SIGNED_EN
    check_all("max_operands", 24'd8);
`else
    check_all("max_operands", 24'd520200);
`endif
    #2 rst_n = 1'b0;
    #1;
    check_all("async_reset_done", 24'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Clr pulsed in the 4th COMPUTE cycle aborts, then a reload is clean.
    set_mat(8'd1, 8'd1);
    load(1'b0);
    ticks(3);
    check_all("clr_pre_abort", 24'd3);
    do_clr();
    check_all("clr_mid_compute", 24'd0);
    ticks(5);
    check_all("clr_stays_fill", 24'd0);
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 8; j++) ma[i][j] = 8'(i + 1);
      vb[i] = 8'(i + 1);
    end
    load(1'b0);
    ticks(8);
    for (int i = 0; i < 8; i++) check_row("reload_after_clr", i, 24'((i + 1) * 36));
    do_clr();

    // 0xFF x 2: signed gives -16, unsigned gives 4080.
    set_mat(8'hFF, 8'd2);
    load(1'b1);
    ticks(8);
`ifdef MVM_SIGNED_EN
    check_all("ff_times_2", 24'hFFFFF0);
`else
    check_all("ff_times_2", 24'd4080);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
